aap_fetch_unit: RTL and testbench

Instruction fetch stage for the AAP 16-bit pipeline, sitting directly upstream of the instruction decoder. It fetches 16-bit words from instruction memory and buffers them in a small prefetch FIFO. It assembles 16- or 32-bit instructions and presents each to the decoder with its PC over a valid/ready handshake. Branch redirects from execute flush the stage and restart fetch at a new word address.

---
 rtl/aap_fetch_unit_if.sv | 33 +++
 rtl/aap_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_aap_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/aap_fetch_unit_if.sv
// AAP fetch stage bus: instruction memory port, redirect and decoder handshake.
// master = fetch unit side, slave = memory/execute/decoder side.
interface aap_fetch_unit_if #(
  parameter int ADDR_W = 24
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              insn_valid;
  logic              insn_ready;
  logic [31:0]       insn_word;
  logic              insn_long;
  logic [ADDR_W-1:0] insn_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output insn_valid, insn_word, insn_long, insn_pc,
    input  insn_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  insn_valid, insn_word, insn_long, insn_pc,
    output insn_ready
  );
endinterface

// File: rtl/aap_fetch_unit.sv
// AAP fetch stage: word prefetch FIFO, 16/32-bit assembly, redirect flush.
// Optional AAP_FETCH_STATS_EN adds a 16-bit accepted-instruction counter.
module aap_fetch_unit #(
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic CLOCK_50,
  input  logic reset,
  aap_fetch_unit_if.master bus
`ifdef AAP_FETCH_STATS_EN
  ,
  output logic [15:0] stat_insn_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] fpc_q;

  logic [15:0]       mw_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mp_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [CW-1:0]     cnt_q;

  logic              ov_q;
  logic              ol_q;
  logic [31:0]       ow_q;
  logic [ADDR_W-1:0] op_q;

  logic [15:0]       head_w;
  logic [15:0]       next_w;
  logic [ADDR_W-1:0] head_p;
  logic              load;
  logic              pop1;
  logic              pop2;
  logic              push;
  logic              credit_idle;
  logic              credit_req;
  logic [CW:0]       pop_n;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] fpc_inc;

  always_comb begin
    head_w  = mw_q[rd_q];
    next_w  = mw_q[rd_q + PW'(1)];
    head_p  = mp_q[rd_q];
    load    = !ov_q || bus.insn_ready;
    pop1    = load && (cnt_q != '0) && !head_w[15];
    pop2    = load && (cnt_q >= CW'(2)) && head_w[15];
    pop_n   = '0;
    if (pop1) pop_n = (CW+1)'(1);
    if (pop2) pop_n = (CW+1)'(2);
    push    = (state_q == REQ) && bus.imem_ack && !bus.redirect;
    // occupancy after this cycle's pops; a live request reserves one slot
    occ         = {1'b0, cnt_q} - pop_n;
    credit_idle = occ < DEPTH_L;
    credit_req  = (occ + (CW+1)'(1)) < DEPTH_L;
    fpc_inc     = fpc_q + ADDR_W'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mw_q[wr_q] <= bus.imem_rdata;
      mp_q[wr_q] <= addr_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      fpc_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      ow_q    <= '0;
      op_q    <= '0;
    end else if (bus.redirect) begin
      fpc_q <= bus.redirect_pc;
      req_q <= 1'b0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      if (state_q == REQ)
        state_q <= bus.imem_ack ? IDLE : DROP;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (credit_idle) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            addr_q  <= fpc_q;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            fpc_q <= fpc_inc;
            if (credit_req) begin
              addr_q <= fpc_inc;
            end else begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase

      if (push) wr_q <= wr_q + PW'(1);
      rd_q  <= rd_q + pop_n[PW-1:0];
      cnt_q <= cnt_q + CW'(push) - pop_n[CW-1:0];

      if (load) begin
        unique case (1'b1)
          pop1: begin
            ov_q <= 1'b1;
            ol_q <= 1'b0;
            ow_q <= {head_w, 16'h0000};
            op_q <= head_p;
          end
          pop2: begin
            ov_q <= 1'b1;
            ol_q <= 1'b1;
            ow_q <= {head_w, next_w};
            op_q <= head_p;
          end
          default: ov_q <= 1'b0;
        endcase
      end
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.insn_valid = ov_q;
  assign bus.insn_word  = ow_q;
  assign bus.insn_long  = ol_q;
  assign bus.insn_pc    = op_q;

`ifdef AAP_FETCH_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)
      stat_q <= '0;
    else if (ov_q && bus.insn_ready)
      stat_q <= stat_q + 16'd1;
  end

  assign stat_insn_count = stat_q;
`endif

endmodule

// File: tb/tb_aap_fetch_unit.sv
// Directed bench for aap_fetch_unit with a latency-programmable memory model.
// Define AAP_FETCH_STATS_EN to also check the accepted-instruction counter.
module tb_aap_fetch_unit;
  localparam int AW = 24;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  aap_fetch_unit_if #(.ADDR_W(AW)) bus ();

`ifdef AAP_FETCH_STATS_EN
  logic [15:0] stat;
`endif

  aap_fetch_unit #(
    .ADDR_W(AW),
    .FIFO_DEPTH(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
`ifdef AAP_FETCH_STATS_EN
    ,
    .stat_insn_count(stat)
`endif
  );

  typedef struct {
    logic [31:0]   w;
    logic          l;
    logic [AW-1:0] pc;
  } rec_t;

  int            checks   = 0;
  int            failures = 0;
  bit [15:0]     mem [bit [AW-1:0]];
  int            lat  = 0;
  int            wcnt = 0;
  bit            pend = 0;
  logic [AW-1:0] paddr = '0;
  bit            acked = 0;
  logic [AW-1:0] ack_addr = '0;
  rec_t          got [$];
  int            hs = 0;
  int            nack = 0;
  bit            saw200 = 0;

  task automatic chk(
    input string       t,
    input logic [63:0] o,
    input logic [63:0] e
  );
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask

  task automatic step();
    bit ack_now;
    bit req_now;
    acked = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    if (bus.imem_req && !pend) begin
      pend  = 1;
      paddr = bus.imem_addr;
      wcnt  = 0;
    end
    if (pend) begin
      if (wcnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem.exists(paddr) ? mem[paddr] : 16'h0000;
      end else begin
        wcnt++;
      end
    end
    if (bus.insn_valid && bus.insn_ready) begin
      got.push_back('{bus.insn_word, bus.insn_long, bus.insn_pc});
      hs++;
      if (bus.insn_pc == 24'h000200) saw200 = 1;
    end
    ack_now = bus.imem_ack;
    req_now = bus.imem_req;
    @(posedge CLOCK_50);
    if (ack_now) begin
      acked    = 1;
      ack_addr = paddr;
      pend     = 0;
      if (req_now) nack++;
    end
    #1;
  endtask

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.insn_ready  = 1'b0;
    mem[24'h000000] = 16'h0001;
    mem[24'h000001] = 16'h0002;
    mem[24'h000002] = 16'h0003;
    mem[24'h000010] = 16'h8123;
    mem[24'h000011] = 16'h4567;
    for (int i = 0; i < 10; i++)
      mem[24'h000020 + AW'(i)] = 16'h0100 + 16'(i);
    mem[24'h000100] = 16'h0AAA;
    mem[24'h000200] = 16'h8ABC;
    mem[24'h000201] = 16'h1111;
    mem[24'h000300] = 16'h0333;
    mem[24'hFFFFFF] = 16'h0FFF;

    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, 24'h000000);
    chk("rst_valid", bus.insn_valid, 1'b0);
    chk("rst_word", bus.insn_word, 32'h00000000);
    chk("rst_long", bus.insn_long, 1'b0);
    chk("rst_pc", bus.insn_pc, 24'h000000);

    reset = 1'b1;
    bus.insn_ready = 1'b1;
    step();
    chk("t1_req", bus.imem_req, 1'b1);
    chk("t1_addr", bus.imem_addr, 24'h000000);
    step();
    chk("t1_valid_pre", bus.insn_valid, 1'b0);
    step();
    chk("t1_valid", bus.insn_valid, 1'b1);
    chk("t1_word0", bus.insn_word, 32'h00010000);
    chk("t1_pc0", bus.insn_pc, 24'h000000);
    for (int i = 0; i < 10 && got.size() < 3; i++) step();
    chk("t1_n", got.size() >= 3, 1'b1);
    chk("t1_g0w", got[0].w, 32'h00010000);
    chk("t1_g1w", got[1].w, 32'h00020000);
    chk("t1_g1pc", got[1].pc, 24'h000001);
    chk("t1_g2w", got[2].w, 32'h00030000);
    chk("t1_g2pc", got[2].pc, 24'h000002);
    chk("t1_g2l", got[2].l, 1'b0);

    bus.redirect = 1'b1;
    bus.redirect_pc = 24'h000010;
    step();
    bus.redirect = 1'b0;
    chk("t2_flush_valid", bus.insn_valid, 1'b0);
    got.delete();
    for (int i = 0; i < 20 && got.size() < 1; i++) step();
    chk("t2_n", got.size() >= 1, 1'b1);
    chk("t2_word", got[0].w, 32'h81234567);
    chk("t2_long", got[0].l, 1'b1);
    chk("t2_pc", got[0].pc, 24'h000010);

    bus.insn_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 24'h000020;
    step();
    bus.redirect = 1'b0;
    got.delete();
    nack = 0;
    repeat (20) step();
    chk("t3_req_low", bus.imem_req, 1'b0);
    chk("t3_acks", nack, 5);
    chk("t3_valid", bus.insn_valid, 1'b1);
    chk("t3_hold_pc", bus.insn_pc, 24'h000020);
    chk("t3_hold_w", bus.insn_word, 32'h01000000);
    bus.insn_ready = 1'b1;
    for (int i = 0; i < 40 && got.size() < 10; i++) step();
    chk("t3_n", got.size() >= 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_pc", got[i].pc, 24'h000020 + AW'(i));
      chk("t3_w", got[i].w, {16'h0100 + 16'(i), 16'h0000});
    end

    lat = 3;
    for (int i = 0; i < 20 && !acked; i++) step();
    chk("t4_pre_req", bus.imem_req, 1'b1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 24'h000100;
    step();
    bus.redirect = 1'b0;
    got.delete();
    chk("t4_drop_req", bus.imem_req, 1'b0);
    chk("t4_drop_valid", bus.insn_valid, 1'b0);
    for (int i = 0; i < 20 && !bus.imem_req; i++) step();
    chk("t4_req", bus.imem_req, 1'b1);
    chk("t4_addr", bus.imem_addr, 24'h000100);
    for (int i = 0; i < 20 && got.size() < 1; i++) step();
    chk("t4_n", got.size() >= 1, 1'b1);
    chk("t4_pc", got[0].pc, 24'h000100);
    chk("t4_w", got[0].w, 32'h0AAA0000);

    bus.redirect = 1'b1;
    bus.redirect_pc = 24'h000200;
    step();
    bus.redirect = 1'b0;
    saw200 = 0;
    for (int i = 0; i < 30 && !(acked && ack_addr == 24'h000200); i++) step();
    chk("t5_half_ack", ack_addr, 24'h000200);
    chk("t5_half_wait", bus.insn_valid, 1'b0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 24'h000300;
    step();
    bus.redirect = 1'b0;
    got.delete();
    for (int i = 0; i < 30 && got.size() < 1; i++) step();
    chk("t5_n", got.size() >= 1, 1'b1);
    chk("t5_pc", got[0].pc, 24'h000300);
    chk("t5_w", got[0].w, 32'h03330000);
    chk("t5_no_half", saw200, 1'b0);

    lat = 0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 24'hFFFFFF;
    step();
    bus.redirect = 1'b0;
    got.delete();
    for (int i = 0; i < 30 && got.size() < 2; i++) step();
    chk("t6_n", got.size() >= 2, 1'b1);
    chk("t6_pc_top", got[0].pc, 24'hFFFFFF);
    chk("t6_w_top", got[0].w, 32'h0FFF0000);
    chk("t6_pc_wrap", got[1].pc, 24'h000000);
    chk("t6_w_wrap", got[1].w, 32'h00010000);

`ifdef AAP_FETCH_STATS_EN
    bus.insn_ready = 1'b0;
    step();
    chk("stat_count", stat, 16'(hs));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
